// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: default widths and the FSM state encoding.
package gcd_pkg;

  localparam int unsigned GCD_W       = 16;
  localparam int unsigned GCD_TIMEOUT = 1024;
  localparam int unsigned OP_COUNT_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StWait,
    StResp
  } gcd_state_e;

endpackage

// File: rtl/gcd_req_timer.sv
// Clearable up-counter with a terminal-count flag for bounding the wait on the GCD core.
module gcd_req_timer
  import gcd_pkg::*;
#(
  parameter int unsigned TIMEOUT = GCD_TIMEOUT,
  parameter int unsigned CW      = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_requester.sv
// Host-side initiator for the iterative GCD core: serialises operand loads, waits for done with a
// timeout, short-circuits zero operands and returns the result on a valid/ready channel.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int unsigned W       = GCD_W,
  parameter int unsigned TIMEOUT = GCD_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_a,
  input  logic [W-1:0]          in_b,
  output logic                  core_start,
  output logic [W-1:0]          core_data,
  input  logic                  core_done,
  input  logic [W-1:0]          core_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_gcd,
  output logic                  out_err,
  output logic [OP_COUNT_W-1:0] op_count
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  if (TIMEOUT < 4) begin : g_bad_timeout
    $error("gcd_requester: TIMEOUT must be at least 4");
  end

  gcd_state_e state_q, state_d;

  logic [W-1:0]          b_q, b_d;
  logic [W-1:0]          core_data_d, out_gcd_d;
  logic                  core_start_d, out_valid_d, out_err_d;
  logic [OP_COUNT_W-1:0] op_count_d;

  logic          tmr_clr, tmr_en, tmr_tc;
  logic [CW-1:0] tmr_count;
  logic          done_seen;

  gcd_req_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .count (tmr_count),
    .tc    (tmr_tc)
  );

  // Held low during reset so no pair is accepted until the FSM is live.
  assign in_ready = (state_q == StIdle) && !rst;

  // First WAIT cycle (count 0) may still see done left over from the previous operation.
  assign done_seen = core_done && (tmr_count != '0);

  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    core_start_d = 1'b0;
    core_data_d  = core_data;
    out_valid_d  = out_valid;
    out_gcd_d    = out_gcd;
    out_err_d    = out_err;
    op_count_d   = op_count;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            out_gcd_d   = in_a | in_b;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StResp;
          end else begin
            core_start_d = 1'b1;
            core_data_d  = in_a;
            state_d      = StLoadA;
          end
        end
      end
      StLoadA: begin
        core_data_d = b_q;
        state_d     = StLoadB;
      end
      StLoadB: begin
        tmr_clr = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        tmr_en = 1'b1;
        if (done_seen) begin
          out_gcd_d   = core_result;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StResp;
        end else if (tmr_tc) begin
          out_gcd_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          op_count_d  = op_count + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      b_q        <= '0;
      core_start <= 1'b0;
      core_data  <= '0;
      out_valid  <= 1'b0;
      out_gcd    <= '0;
      out_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      state_q    <= state_d;
      b_q        <= b_d;
      core_start <= core_start_d;
      core_data  <= core_data_d;
      out_valid  <= out_valid_d;
      out_gcd    <= out_gcd_d;
      out_err    <= out_err_d;
      op_count   <= op_count_d;
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Scoreboard bench for gcd_requester with a behavioural GCD core model that can be stubbed.
module tb_gcd_requester;

  localparam int W  = 16;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          core_start;
  logic [W-1:0]  core_data;
  logic          core_done;
  logic [W-1:0]  core_result;
  logic          out_valid, out_ready, out_err;
  logic [W-1:0]  out_gcd;
  logic [15:0]   op_count;

  always #5 clk = ~clk;

  gcd_requester #(
    .W       (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err),
    .op_count    (op_count)
  );

  typedef struct packed {
    logic [W-1:0] gcd;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a;
    logic [W-1:0] y = b;
    logic [W-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: takes A with start, B next cycle, keeps done high until two cycles into the next op.
  logic         stub = 1'b0;
  logic [W-1:0] ma = '0, mb = '0;
  int           mph = 0, mk = 0, mlat = 0;

  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mph       = 0;
        core_done = 1'b0;
      end else begin
        case (mph)
          0: if (core_start) begin
            ma  = core_data;
            mph = 1;
          end
          1: begin
            check("start_pulse_width", core_start, 0);
            mb   = core_data;
            mk   = 0;
            mlat = $urandom_range(3, 12);
            mph  = 2;
          end
          default: begin
            mk++;
            if (mk == 2) core_done = 1'b0;
            if (mk == mlat) begin
              core_result = ref_gcd(ma, mb);
              core_done   = !stub;
              mph         = 0;
            end
          end
        endcase
      end
    end
  end

  // Single driver for out_ready: random backpressure or a fixed level.
  logic rand_ready  = 1'b0;
  logic fixed_ready = 1'b1;
  always @(posedge clk) begin
    #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Monitor / scoreboard
  int           negcnt = 0, acc_neg = 0, last_lat = 0, start_lat = 0;
  int           popped = 0, exp_opc = 0, exp_starts = 0, starts_seen = 0;
  logic         busy = 1'b0, seen_valid = 1'b0, prev_start = 1'b0, prev_hold = 1'b0;
  logic [W-1:0] hold_gcd = '0;
  logic         hold_err = 1'b0;
  exp_t         e;

  always @(negedge clk) begin
    negcnt++;
    if (rst) begin
      q.delete();
      busy       = 1'b0;
      seen_valid = 1'b0;
      prev_hold  = 1'b0;
      prev_start = 1'b0;
      exp_opc    = 0;
    end else begin
      check("in_ready", in_ready, !busy);
      check("op_count", op_count, exp_opc[15:0]);
      if (core_start && !prev_start) begin
        starts_seen++;
        start_lat = negcnt - acc_neg;
      end
      prev_start = core_start;
      if (out_valid && !seen_valid) begin
        last_lat   = negcnt - acc_neg;
        seen_valid = 1'b1;
      end
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_gcd", out_gcd, hold_gcd);
        check("hold_err", out_err, hold_err);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_result", out_valid, 0);
        end else begin
          e = q.pop_front();
          check("out_gcd", out_gcd, e.gcd);
          check("out_err", out_err, e.err);
        end
        popped++;
        exp_opc    = exp_opc + 1;
        seen_valid = 1'b0;
        busy       = 1'b0;
      end
      prev_hold = out_valid && !out_ready;
      hold_gcd  = out_gcd;
      hold_err  = out_err;
      if (in_valid && in_ready) begin
        if (in_a == 0 || in_b == 0) e = '{gcd: in_a | in_b, err: 1'b0};
        else if (stub)              e = '{gcd: '0, err: 1'b1};
        else                        e = '{gcd: ref_gcd(in_a, in_b), err: 1'b0};
        if (in_a != 0 && in_b != 0) exp_starts++;
        q.push_back(e);
        busy    = 1'b1;
        acc_neg = negcnt;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      check("in_ready_wait", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (popped < target && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("resp_count", popped, target);
  endtask

  function automatic logic [W-1:0] rnd_op();
    int r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r < 4)  return W'($urandom_range(1, 60));
    return W'($urandom_range(1, 65535));
  endfunction

  int s0, base, n;

  initial begin
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_data", core_data, 0);
    check("rst_out_gcd", out_gcd, 0);
    check("rst_out_err", out_err, 0);
    check("rst_op_count", op_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("in_ready_after_reset", in_ready, 1);

    // Basic
    send(16'd6, 16'd4);
    wait_resp(1);
    check("start_latency", start_lat, 1);
    check("core_bus_a", ma, 6);
    check("core_bus_b", mb, 4);

    // Back-to-back, exercises stale done from the previous op
    send(16'd48, 16'd18);
    send(16'd17, 16'd5);
    wait_resp(3);

    // Zero operands
    s0 = starts_seen;
    send(16'd0, 16'd9);
    wait_resp(4);
    check("zero_latency", last_lat, 1);
    send(16'd0, 16'd0);
    wait_resp(5);
    check("zero_no_start", starts_seen, s0);

    // Timeout
    stub = 1'b1;
    send(16'd12, 16'd8);
    wait_resp(6);
    check("timeout_latency", last_lat, TO + 3);
    stub = 1'b0;

    // Backpressure
    fixed_ready = 1'b0;
    send(16'd6, 16'd4);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_op_count", op_count, 6);
    end
    fixed_ready = 1'b1;
    wait_resp(7);

    // Reset in the middle of WAIT
    send(16'd48, 16'd18);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_core_start", core_start, 0);
    check("mid_rst_core_data", core_data, 0);
    check("mid_rst_out_gcd", out_gcd, 0);
    check("mid_rst_out_err", out_err, 0);
    check("mid_rst_op_count", op_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    base = popped;
    send(16'd6, 16'd4);
    wait_resp(base + 1);
    @(negedge clk);
    check("post_rst_op_count", op_count, 1);

    // Random traffic with random backpressure
    rand_ready = 1'b1;
    base = popped;
    for (int i = 0; i < 40; i++) send(rnd_op(), rnd_op());
    wait_resp(base + 40);
    rand_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    check("start_count", starts_seen, exp_starts);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
